// File: rtl/inst_queue_pkg.sv
// Shared width/depth defaults and helpers for the instruction queue.
// Default widths: 8-bit memory bus and 16-bit instructions, which gives two beats per instruction.
package inst_queue_pkg;

  localparam int DEF_DATA_BUS_WIDTH    = 8;
  localparam int DEF_INSTRUCTION_WIDTH = 16;
  localparam int INST_QUEUE_DEPTH      = 4;
  localparam int OVERRUN_LIMIT         = 16;

  function automatic int beats_of(input int inst_width, input int bus_width);
    return inst_width / bus_width;
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Memory-side beat stream plus decoder-side instruction stream, valid/ready on both.
// The slave modport is the queue; the master modport is the memory/decoder environment.
interface inst_queue_if
  import inst_queue_pkg::*;
#(
  parameter int DATA_BUS_WIDTH    = DEF_DATA_BUS_WIDTH,
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH
);

  logic [DATA_BUS_WIDTH-1:0]    in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         inst_valid;
  logic                         inst_ready;

  modport master (
    output in_data, in_valid, inst_ready,
    input  in_ready, instruction, inst_valid
  );

  modport slave (
    input  in_data, in_valid, inst_ready,
    output in_ready, instruction, inst_valid
  );

endinterface

// File: rtl/inst_beat_assembler.sv
// Collects BEATS bus beats (first beat in the LSBs) into one instruction.
// The push strobe is combinational in the final-beat accept cycle; the caller owns backpressure.
module inst_beat_assembler
  import inst_queue_pkg::*;
#(
  parameter int DATA_BUS_WIDTH    = DEF_DATA_BUS_WIDTH,
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [DATA_BUS_WIDTH-1:0]    i_data,
  input  logic                         i_accept,
  output logic                         o_last,
  output logic [INSTRUCTION_WIDTH-1:0] o_inst,
  output logic                         o_push
);

  localparam int BEATS = beats_of(INSTRUCTION_WIDTH, DATA_BUS_WIDTH);

  generate
    if (BEATS == 1) begin : g_single
      assign o_last = 1'b1;
      assign o_inst = i_data;
      assign o_push = i_accept && !flush;
    end else begin : g_multi
      localparam int CW = $clog2(BEATS);
      localparam int PW = INSTRUCTION_WIDTH - DATA_BUS_WIDTH;
      localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

      logic [CW-1:0] r_beat_cnt;
      logic [PW-1:0] r_partial;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_beat_cnt <= '0;
          r_partial  <= '0;
        end else if (flush) begin
          r_beat_cnt <= '0;
          r_partial  <= '0;
        end else if (i_accept) begin
          if (r_beat_cnt == LAST_BEAT) begin
            r_beat_cnt <= '0;
          end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            for (int k = 0; k < BEATS - 1; k++) begin
              if (r_beat_cnt == CW'(k)) begin
                r_partial[k*DATA_BUS_WIDTH +: DATA_BUS_WIDTH] <= i_data;
              end
            end
          end
        end
      end

      assign o_last = (r_beat_cnt == LAST_BEAT);
      assign o_inst = {i_data, r_partial};
      assign o_push = i_accept && o_last && !flush;
    end
  endgenerate

endmodule

// File: rtl/inst_queue.sv
// Beat assembler feeding a DEPTH-entry instruction FIFO; inst_valid rises one cycle after the final beat, no bypass.
// in_ready depends on registered state only; INST_QUEUE_COUNT_EN adds occupancy and a sticky overrun_err.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DATA_BUS_WIDTH    = DEF_DATA_BUS_WIDTH,
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
  parameter int DEPTH             = INST_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  inst_queue_if.slave                bus
`ifdef INST_QUEUE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overrun_err
`endif
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PTRW-1:0] LAST_IDX = PTRW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic                         w_accept;
  logic                         w_last;
  logic                         w_push;
  logic                         w_pop;
  logic [INSTRUCTION_WIDTH-1:0] w_inst;

  logic [INSTRUCTION_WIDTH-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]              r_wr_ptr;
  logic [PTRW-1:0]              r_rd_ptr;
  logic [CNTW-1:0]              r_count;

  // Only the final beat needs a free slot; earlier beats land in the partial register.
  assign bus.in_ready    = !w_last || (r_count != FULL_CNT);
  assign bus.inst_valid  = (r_count != '0);
  assign bus.instruction = r_mem[r_rd_ptr];

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_pop    = bus.inst_valid && bus.inst_ready && !flush;

  inst_beat_assembler #(
    .DATA_BUS_WIDTH    (DATA_BUS_WIDTH),
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .i_data   (bus.in_data),
    .i_accept (w_accept),
    .o_last   (w_last),
    .o_inst   (w_inst),
    .o_push   (w_push)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_inst;
        r_wr_ptr        <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef INST_QUEUE_COUNT_EN
  localparam logic [3:0] STALL_LAST = 4'(OVERRUN_LIMIT - 1);

  logic [3:0] r_stall_cnt;
  logic       r_overrun_err;

  // Counts consecutive stalled cycles; the sixteenth one latches the error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt   <= '0;
      r_overrun_err <= 1'b0;
    end else if (flush) begin
      r_stall_cnt   <= '0;
      r_overrun_err <= 1'b0;
    end else if (bus.in_valid && !bus.in_ready) begin
      if (r_stall_cnt == STALL_LAST) begin
        r_overrun_err <= 1'b1;
      end else begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end else begin
      r_stall_cnt <= '0;
    end
  end

  assign occupancy   = r_count;
  assign overrun_err = r_overrun_err;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue at BEATS=2, DEPTH=4: assembly, full stall, wrap, flush, async reset.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] q[$];
  logic [15:0] v;

  inst_queue_if bus ();

`ifdef INST_QUEUE_COUNT_EN
  logic [2:0] occ;
  logic       oerr;
  inst_queue dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus),
                  .occupancy(occ), .overrun_err(oerr));
`else
  inst_queue dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.inst_ready = 1'b0;
    #2;
    chk("reset_inst_valid", 32'(bus.inst_valid), 0);
    chk("reset_instruction", 32'(bus.instruction), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_reset_in_ready", 32'(bus.in_ready), 1);

    // Basic assembly and pop
    bus.inst_ready = 1'b1;
    send(8'h34);
    chk("t1_no_valid_after_first_beat", 32'(bus.inst_valid), 0);
    send(8'h12);
    chk("t1_valid", 32'(bus.inst_valid), 1);
    chk("t1_instruction", 32'(bus.instruction), 32'h1234);
    tick();
    chk("t1_popped", 32'(bus.inst_valid), 0);

    // Fill, stall final beat, drain
    bus.inst_ready = 1'b0;
    send(8'hB2); send(8'hA1); send(8'hC3); send(8'hB2);
    send(8'hD4); send(8'hC3); send(8'hE5); send(8'hD4);
`ifdef INST_QUEUE_COUNT_EN
    chk("t2_occupancy_full", 32'(occ), 4);
`endif
    chk("t2_head", 32'(bus.instruction), 32'hA1B2);
    bus.in_valid = 1'b1; bus.in_data = 8'h0D;
    chk("t2_first_beat_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_data = 8'hF0;
    chk("t2_final_beat_stalled", 32'(bus.in_ready), 0);
    tick();
    chk("t2_still_stalled", 32'(bus.in_ready), 0);
    bus.inst_ready = 1'b1;
    tick();
    chk("t2_pop1_ready", 32'(bus.in_ready), 1);
    chk("t2_pop1_head", 32'(bus.instruction), 32'hB2C3);
    tick();
    bus.in_valid = 1'b0;
    chk("t2_pop2_head", 32'(bus.instruction), 32'hC3D4);
    tick();
    chk("t2_pop3_head", 32'(bus.instruction), 32'hD4E5);
    tick();
    chk("t2_stalled_inst", 32'(bus.instruction), 32'hF00D);
    tick();
    chk("t2_empty", 32'(bus.inst_valid), 0);

    // Simultaneous push/pop at count=2 with pointer wrap
    bus.inst_ready = 1'b0;
    send(8'h01); send(8'h10);
    send(8'h02); send(8'h10);
    q.push_back(16'h1001); q.push_back(16'h1002);
    for (int i = 0; i < 5; i++) begin
      v = {8'hC0 + 8'(i), 8'h20 + 8'(i)};
      bus.inst_ready = 1'b0;
      send(v[7:0]);
      bus.inst_ready = 1'b1;
      send(v[15:8]);
      bus.inst_ready = 1'b0;
      q.push_back(v);
      void'(q.pop_front());
      chk("t3_head", 32'(bus.instruction), 32'(q[0]));
`ifdef INST_QUEUE_COUNT_EN
      chk("t3_occupancy", 32'(occ), 2);
`endif
    end
    bus.inst_ready = 1'b1;
    chk("t3_drain0", 32'(bus.instruction), 32'(q[0]));
    tick();
    chk("t3_drain1", 32'(bus.instruction), 32'(q[1]));
    tick();
    chk("t3_drained", 32'(bus.inst_valid), 0);

    // Flush drops the beat presented with it
    bus.inst_ready = 1'b0;
    send(8'h55);
    bus.in_valid = 1'b1; bus.in_data = 8'h66; flush = 1'b1;
    tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("t4_flush_empty", 32'(bus.inst_valid), 0);
    send(8'h01); send(8'h02);
    chk("t4_after_flush_valid", 32'(bus.inst_valid), 1);
    chk("t4_after_flush_inst", 32'(bus.instruction), 32'h0201);
    bus.inst_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; bus.inst_ready = 1'b0;
    chk("t4_flush_queue", 32'(bus.inst_valid), 0);

    // Asynchronous reset mid-cycle with count=3 and a partial beat
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    send(8'h99);
    chk("t5_valid_before_rst", 32'(bus.inst_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk("t5_async_inst_valid", 32'(bus.inst_valid), 0);
    chk("t5_async_instruction", 32'(bus.instruction), 0);
    #2 rst = 1'b0;
    tick();
    chk("t5_in_ready_after_rst", 32'(bus.in_ready), 1);
    send(8'h77); send(8'h88);
    chk("t5_partial_cleared", 32'(bus.instruction), 32'h8877);

`ifdef INST_QUEUE_COUNT_EN
    // Overrun: final beat held stalled for sixteen cycles
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(i));
    chk("t6_full", 32'(occ), 4);
    send(8'hAA);
    bus.in_valid = 1'b1; bus.in_data = 8'hBB;
    for (int i = 0; i < 15; i++) tick();
    chk("t6_no_err_at_15", 32'(oerr), 0);
    tick();
    chk("t6_err_at_16", 32'(oerr), 1);
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("t6_err_sticky", 32'(oerr), 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t6_err_cleared", 32'(oerr), 0);
    chk("t6_occ_cleared", 32'(occ), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised successor to the single-register instruction latch.
- Assembles BEATS = INSTRUCTION_WIDTH/DATA_BUS_WIDTH bus beats into one instruction and buffers up to DEPTH instructions in a FIFO.
- Sits between the memory data bus and the decoder; handshake is valid/ready on both sides, with a synchronous flush for branches and jumps.

Parameters:
- DATA_BUS_WIDTH, default from param.v (8): width of one bus beat.
- INSTRUCTION_WIDTH, default from param.v (16): instruction width. Must be an integer multiple of DATA_BUS_WIDTH, with a ratio of 1 or more.
- DEPTH, default 4: FIFO entries, DEPTH >= 2. Need not be a power of two.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_BUS_WIDTH  instruction beat from memory.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  beat is accepted when in_valid && in_ready.
- flush  in  1  synchronous discard of all buffered and partial state.
- instruction  out  INSTRUCTION_WIDTH  head-of-queue instruction.
- inst_valid  out  1  instruction is valid (queue not empty).
- inst_ready  in  1  decoder pops the head when inst_valid && inst_ready.

Behaviour:
- Reset (async, rst=1):
  - beat_cnt, partial register, wr_ptr, rd_ptr and count go to 0.
  - All FIFO entries go to 0, so instruction=0 and inst_valid=0.
  - in_ready=1 once rst is released.
- Beat assembly:
  - beat_cnt runs 0..BEATS-1.
  - Beat k lands in bits [k*DATA_BUS_WIDTH +: DATA_BUS_WIDTH]; the first beat goes to the LSBs.
  - Beats 0..BEATS-2 are stored in the partial register.
  - An accepted last beat writes {in_data, partial} into mem[wr_ptr] and sets beat_cnt to 0.
  - When BEATS=1 there is no partial register; each beat is a full instruction.
- in_ready = (beat_cnt != BEATS-1) || (count != DEPTH).
  - in_ready is purely registered-state based and never depends on inst_ready (no combinational path).
  - A full queue still accepts non-final beats.
- Output:
  - instruction = mem[rd_ptr] and inst_valid = (count != 0), both combinational from registers.
  - Latency: inst_valid rises the cycle after the final beat is accepted; there is no bypass.
  - instruction holds stable while inst_valid && !inst_ready.
- Pointers wrap explicitly from DEPTH-1 to 0.
- count has width $clog2(DEPTH+1).
  - A simultaneous push and pop leaves count unchanged and advances both pointers.
- Full: the final beat is stalled (in_ready=0). A pop in that cycle frees the slot, and the beat is accepted in the following cycle.
- Empty: popping is impossible because inst_valid=0, so inst_ready is ignored.
- Flush:
  - On a clock edge with flush=1: pointers, count and beat_cnt go to 0 and the partial register is cleared.
  - Any beat or pop presented in the same cycle is discarded.
  - Flush has priority over everything except rst.
  - Memory contents are not cleared, but inst_valid=0 the next cycle.
- rst asserted mid-assembly or while the queue is non-empty: all state clears immediately, without waiting for clk.

Optional Feature:
- Macro: INST_QUEUE_COUNT_EN.
- Defined: adds output port `occupancy` [$clog2(DEPTH+1)-1:0] = count, plus a sticky output `overrun_err`.
  - overrun_err sets when in_valid is held high for 16 consecutive cycles with in_ready=0.
  - It clears on rst or flush.
- Undefined: neither port exists and no extra logic is generated.

Decomposition:
- param.v (shared include) holds DATA_BUS_WIDTH, INSTRUCTION_WIDTH and a new INST_QUEUE_DEPTH constant, which is the DEPTH default.
- The BEATS constant is derived locally as a localparam.
- One sub-module: inst_beat_assembler.
  - Owns beat_cnt and the partial register.
  - Emits a full instruction plus a one-cycle push strobe.
  - Takes flush and rst.
- The FIFO storage and pointers stay in inst_queue.

Test Plan:
- BEATS=2, DEPTH=4, inst_ready=1: send beats 0x34 then 0x12 -> instruction=0x1234 and inst_valid=1 exactly one cycle after the second beat; inst_valid falls after the pop.
- inst_ready=0, push 4 instructions 0xA1B2..0xD4E5 -> count=4; a fifth instruction's first beat is accepted and its second beat sees in_ready=0. Raise inst_ready -> pops come out in order, and the stalled beat is accepted the cycle after the first pop.
- Simultaneous push and pop with count=2 over 10 cycles -> count stays at 2. Pointers wrap past 3, and the data order is preserved.
- After the first beat 0x55, assert flush together with a second beat 0x66 -> beat is dropped, inst_valid=0, and the next pair 0x01,0x02 yields 0x0201.
- Assert rst asynchronously mid-cycle with count=3 -> inst_valid=0 and instruction=0 before the next clk edge; in_ready=1 after release.
- With INST_QUEUE_COUNT_EN: hold the queue full with in_valid=1 for 16 cycles -> overrun_err=1 and stays 1 until flush.
